// File: rtl/slc3_sram.sv
// rtl/slc3_sram.sv - SLC-3 on-chip program/data SRAM with stream-driven program loader
module slc3_sram #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_LEN,
    DATA,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wptr;
  logic [15:0]       remaining;
  logic              beat;
  logic              loader_wr;
  logic              cpu_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W-1:0] cpu_addr;
  logic              unused_bits;

  assign cpu_addr    = ADDR[ADDR_W-1:0];
  assign unused_bits = ^{ADDR[15:ADDR_W]};

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (load_start) state_nxt = HDR_ADDR;
      end
      HDR_ADDR: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = HDR_LEN;
      end
      HDR_LEN: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = (load_data == 16'd0) ? DONE : DATA;
      end
      DATA: begin
        load_ready = 1'b1;
        if (load_valid && remaining == 16'd1) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat = load_valid & load_ready;

  // Single write port: the loader owns it during a session, the CPU only in IDLE.
  assign loader_wr = (state == DATA) && beat;
  assign cpu_wr    = (state == IDLE) && WE;
  assign mem_we    = !Reset && (loader_wr || cpu_wr);
  assign mem_waddr = loader_wr ? wptr : cpu_addr;
  assign mem_wdata = loader_wr ? load_data : Data_to_SRAM;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      base           <= '0;
      wptr           <= '0;
      remaining      <= 16'd0;
      load_err       <= 1'b0;
      Data_from_SRAM <= 16'h0000;
    end else begin
      if (state == IDLE && load_start) load_err <= 1'b0;
      if (state == HDR_ADDR && beat) base <= load_data[ADDR_W-1:0];
      if (state == HDR_LEN && beat) begin
        remaining <= load_data;
        wptr      <= base;
      end
      if (loader_wr) begin
        wptr      <= wptr + ADDR_W'(1);
        remaining <= remaining - 16'd1;
        // Wrapping with words still to come means the image overran the top of memory.
        if ((&wptr) && remaining > 16'd1) load_err <= 1'b1;
      end
      if (OE) Data_from_SRAM <= mem[cpu_addr];
    end
  end

endmodule

// File: tb/tb_slc3_sram.sv
// tb/tb_slc3_sram.sv - self-checking bench for slc3_sram
module tb_slc3_sram;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] ADDR = 16'd0;
  logic        OE = 1'b0;
  logic        WE = 1'b0;
  logic [15:0] Data_to_SRAM = 16'd0;
  logic [15:0] Data_from_SRAM;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'd0;
  logic        load_ready;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  slc3_sram #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
    .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_dout = 16'd0;

  typedef struct {
    logic [15:0] addr;
    logic        oe;
    logic        we;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; Data_to_SRAM = d; WE = 1'b1;
    tick();
    WE = 1'b0;
    model_mem[a[ADDR_W-1:0]] = d;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    ADDR = a; OE = 1'b1;
    tick();
    OE = 1'b0;
    d = Data_from_SRAM;
    model_dout = model_mem[a[ADDR_W-1:0]];
  endtask

  task automatic sweep(input string tag);
    logic [15:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(16'(i), d);
      check($sformatf("%s[%0h]", tag, i), d, model_mem[i]);
    end
  endtask

  task automatic session(input int base, input int len, input bit toggle,
                         input bit cpu_we, input bit fixed);
    logic [15:0] w[$];
    logic [15:0] last_a;
    int cyc, beats, hold_cnt, done_cnt;
    bit fin, exp_err;
    w.push_back(16'(base));
    w.push_back(16'(len));
    for (int i = 0; i < len; i++)
      w.push_back(fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom));
    exp_err = (len > 0) && (base + len > DEPTH);
    cyc = 0; beats = 0; hold_cnt = 0; done_cnt = 0; fin = 0; last_a = 16'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("hold_rise", cpu_hold, 1'b1);
    check("ready_hdr", load_ready, 1'b1);
    check("err_cleared", load_err, 1'b0);
    while (cyc < 200 && !fin) begin
      if (!cpu_hold) fin = 1;
      else begin
        hold_cnt++;
        if (load_done) done_cnt++;
        load_valid = (beats < w.size()) && (!toggle || cyc % 2 == 0);
        load_data  = load_valid ? w[beats] : 16'($urandom);
        if (load_valid && load_ready) beats++;
        if (cpu_we) begin
          ADDR = 16'($urandom); last_a = ADDR;
          WE = 1'b1; OE = 1'b1; Data_to_SRAM = 16'($urandom);
        end
        tick();
        cyc++;
      end
    end
    load_valid = 1'b0; WE = 1'b0; OE = 1'b0;
    check("sess_terminated", fin, 1'b1);
    check("sess_beats", beats, w.size());
    check("done_pulses", done_cnt, 1);
    if (!toggle) check("hold_cycles", hold_cnt, len + 3);
    check("load_err", load_err, exp_err);
    if (cpu_we) check("read_during_load", Data_from_SRAM, model_mem[last_a[ADDR_W-1:0]]);
    for (int i = 0; i < len; i++) model_mem[(base + i) % DEPTH] = w[i + 2];
  endtask

  initial begin
    logic [15:0] d, a, din;
    logic        oe, we;
    logic [15:0] exp;

    vt[0] = '{16'h0005, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    vt[1] = '{16'h0005, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
    vt[2] = '{16'h0405, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
    vt[3] = '{16'h0007, 1'b0, 1'b1, 16'h1234, 16'hBEEF};
    vt[4] = '{16'h0007, 1'b1, 1'b1, 16'h5678, 16'h1234};
    vt[5] = '{16'h0007, 1'b1, 1'b0, 16'h0000, 16'h5678};
    vt[6] = '{16'hFC07, 1'b1, 1'b0, 16'h0000, 16'h5678};

    tick(); tick();
    check("rst_dout", Data_from_SRAM, 16'h0000);
    check("rst_ready", load_ready, 1'b0);
    check("rst_hold", cpu_hold, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", load_err, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      ADDR = vt[i].addr; OE = vt[i].oe; WE = vt[i].we; Data_to_SRAM = vt[i].din;
      tick();
      check($sformatf("vec%0d", i), Data_from_SRAM, vt[i].exp);
    end
    OE = 1'b0; WE = 1'b0;

    for (int i = 0; i < DEPTH; i++) cpu_write(16'(i), 16'($urandom));

    session(16'h0010, 3, 1'b0, 1'b0, 1'b1);
    sweep("load_b2b");
    session(16'h0010, 3, 1'b1, 1'b0, 1'b0);
    sweep("load_toggle");
    session(16'h03FE, 4, 1'b0, 1'b0, 1'b1);
    sweep("load_wrap");
    session(16'h0050, 0, 1'b0, 1'b1, 1'b0);
    sweep("load_len0");

    for (int r = 0; r < 5; r++)
      session($urandom_range(0, DEPTH - 1), $urandom_range(0, 12), 1'($urandom), 1'b0, 1'b0);
    sweep("load_rand");

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom); oe = 1'($urandom); we = 1'($urandom); din = 16'($urandom);
      exp = oe ? model_mem[a[ADDR_W-1:0]] : model_dout;
      ADDR = a; OE = oe; WE = we; Data_to_SRAM = din;
      tick();
      check($sformatf("rand_cpu%0d", i), Data_from_SRAM, exp);
      model_dout = exp;
      if (we) model_mem[a[ADDR_W-1:0]] = din;
    end
    OE = 1'b0; WE = 1'b0;

    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 16'h0100; tick();
    load_data = 16'd5;    tick();
    load_data = 16'hA001; tick();
    load_data = 16'hA002; tick();
    model_mem[16'h100] = 16'hA001;
    model_mem[16'h101] = 16'hA002;
    Reset = 1'b1; load_data = 16'hA003;
    tick();
    Reset = 1'b0; load_data = 16'hA004;
    check("mid_rst_hold", cpu_hold, 1'b0);
    check("mid_rst_ready", load_ready, 1'b0);
    check("mid_rst_dout", Data_from_SRAM, 16'h0000);
    tick();
    load_valid = 1'b0;
    check("post_rst_hold", cpu_hold, 1'b0);
    model_dout = 16'h0000;
    sweep("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
